// File: rtl/arb_pkg.sv
// ============================================================================
// Module   : arb_pkg
// Brief    : Shared types, default sizes and grant helper for reg_bank_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

package arb_pkg;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    localparam int C_NUM_REQ = 4;
    localparam int C_DATA_W  = 16;
    localparam int C_DEPTH   = 8;
    localparam int C_MAX_REQ = 8;

    // Fixed-width grant vector; callers slice it down to their NUM_REQ.
    function automatic logic [C_MAX_REQ-1:0] onehot(input logic [2:0] idx);
        logic [C_MAX_REQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

`default_nettype wire

// File: rtl/reg_bank_arbiter_if.sv
// ============================================================================
// Module   : reg_bank_arbiter_if
// Brief    : Requester-side bus of the arbitrated register bank. The lock
//            signal exists only when ARB_LOCK_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

interface reg_bank_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 3,
    parameter int IDX_W   = $clog2(NUM_REQ)
);
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ-1:0]        we;
    logic [NUM_REQ*ADDR_W-1:0] addr;
    logic [NUM_REQ*DATA_W-1:0] wdata;
`ifdef ARB_LOCK_EN
    logic [NUM_REQ-1:0]        lock;
`endif
    logic [NUM_REQ-1:0]        gnt;
    logic                      rvalid;
    logic [DATA_W-1:0]         rdata;
    logic [IDX_W-1:0]          rid;

    modport master (
        output req, we, addr, wdata,
`ifdef ARB_LOCK_EN
        output lock,
`endif
        input  gnt, rvalid, rdata, rid
    );

    modport slave (
        input  req, we, addr, wdata,
`ifdef ARB_LOCK_EN
        input  lock,
`endif
        output gnt, rvalid, rdata, rid
    );

endinterface

`default_nettype wire

// File: rtl/reg_bank_arbiter_rr_pick.sv
// ============================================================================
// Module   : rr_pick
// Brief    : Combinational round-robin picker, first set req at or above ptr
//            with wrap-around.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  wire logic [NUM_REQ-1:0] req,
    input  wire logic [IDX_W-1:0]   ptr,
    output logic      [IDX_W-1:0]   winner,
    output logic                    any_req
);

    // Scan offsets from farthest to nearest so the nearest hit is kept last.
    always_comb begin
        winner  = '0;
        any_req = 1'b0;
        for (int off = NUM_REQ - 1; off >= 0; off--) begin
            int idx;
            idx = (int'(ptr) + off) % NUM_REQ;
            if (req[idx[IDX_W-1:0]]) begin
                winner  = idx[IDX_W-1:0];
                any_req = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/reg_bank_arbiter.sv
// ============================================================================
// Module   : reg_bank_arbiter
// Brief    : Round-robin arbitrated 8x16 register bank, one op per 2 cycles.
//            Define ARB_LOCK_EN to add the per-requester keep-grant lock.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module reg_bank_arbiter
    import arb_pkg::*;
#(
    parameter int NUM_REQ = C_NUM_REQ,
    parameter int DATA_W  = C_DATA_W,
    parameter int DEPTH   = C_DEPTH
) (
    input wire logic         clk,
    input wire logic         rst_n,
    reg_bank_arbiter_if.slave bus
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam int IDX_W  = $clog2(NUM_REQ);

    localparam logic [0:0] C_IDLE   = IDLE;
    localparam logic [0:0] C_ACCESS = ACCESS;

    logic [0:0]         r_state;
    logic [IDX_W-1:0]   r_ptr;
    logic [NUM_REQ-1:0] r_gnt;
    logic               r_rvalid;
    logic [DATA_W-1:0]  r_rdata;
    logic [IDX_W-1:0]   r_rid;
    logic               r_we;
    logic [ADDR_W-1:0]  r_addr;
    logic [DATA_W-1:0]  r_wdata;
    logic [IDX_W-1:0]   r_owner;
    logic [DATA_W-1:0]  r_mem [DEPTH];

    logic [IDX_W-1:0]     w_winner;
    logic                 w_any_req;
    logic [IDX_W-1:0]     w_ptr_next;
    logic [C_MAX_REQ-1:0] w_onehot;
    logic                 w_in_range;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_pick (
        .req     (bus.req),
        .ptr     (r_ptr),
        .winner  (w_winner),
        .any_req (w_any_req)
    );

    assign w_onehot = onehot(3'(w_winner));

    always_comb begin
        w_ptr_next = (w_winner == IDX_W'(NUM_REQ - 1)) ? '0 : w_winner + 1'b1;
`ifdef ARB_LOCK_EN
        if (bus.lock[w_winner]) begin
            w_ptr_next = w_winner;
        end
`endif
    end

    // Only a non power-of-two DEPTH leaves unused address codes.
    generate
        if (DEPTH < (2 ** ADDR_W)) begin : g_range
            assign w_in_range = (r_addr < ADDR_W'(DEPTH));
        end else begin : g_full
            assign w_in_range = 1'b1;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= C_IDLE;
            r_ptr    <= '0;
            r_gnt    <= '0;
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
            r_rid    <= '0;
            r_we     <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_owner  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            r_rvalid <= 1'b0;
            case (r_state)
                C_IDLE: begin
                    if (w_any_req) begin
                        r_state <= C_ACCESS;
                        r_gnt   <= w_onehot[NUM_REQ-1:0];
                        r_we    <= bus.we[w_winner];
                        r_addr  <= bus.addr[int'(w_winner)*ADDR_W +: ADDR_W];
                        r_wdata <= bus.wdata[int'(w_winner)*DATA_W +: DATA_W];
                        r_owner <= w_winner;
                        r_ptr   <= w_ptr_next;
                    end
                end
                C_ACCESS: begin
                    r_state <= C_IDLE;
                    r_gnt   <= '0;
                    if (r_we) begin
                        if (w_in_range) begin
                            r_mem[r_addr] <= r_wdata;
                        end
                    end else begin
                        r_rvalid <= 1'b1;
                        r_rdata  <= w_in_range ? r_mem[r_addr] : '0;
                        r_rid    <= r_owner;
                    end
                end
                default: begin
                    r_state <= C_IDLE;
                end
            endcase
        end
    end

    assign bus.gnt    = r_gnt;
    assign bus.rvalid = r_rvalid;
    assign bus.rdata  = r_rdata;
    assign bus.rid    = r_rid;

endmodule

`default_nettype wire
